frameblock_buffer: RTL and testbench

//  Ping-pong frame-block store between the renderer and lcd_driver. Renderer writes one
//  1024-pixel RGB565 block into the back bank while lcd_driver reads the front bank.

---
 rtl/frameblock_buffer.sv | 118 +++++++++++
 tb/tb_frameblock_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frameblock_buffer.sv
// frameblock_buffer: ping-pong store of 1024-pixel RGB565 blocks between the
// renderer (writes the back bank) and the lcd_driver (reads the front bank).
// Each committed block carries an id; ids cycle 0..NUM_BLOCKS-1 over a frame,
// and releasing the last id of a frame raises a one-cycle frame_end pulse.
//
// Handshake: the renderer may write or commit only while render_ready is high
// (strobes seen while it is low are dropped); the lcd_driver may release the
// front bank only while frameblock_ready is high (frameblock_next is ignored
// otherwise). Both ready flags are combinational views of bank ownership.
module frameblock_buffer #(
    parameter int NUM_BLOCKS = 75,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] render_addr,
    input  logic [15:0]       render_data,
    input  logic              render_we,
    input  logic              render_done,
    output logic              render_ready,
    output logic [6:0]        render_block_id,
    input  logic [ADDR_W-1:0] frameblock_addr,
    output logic [15:0]       frameblock_data,
    output logic [6:0]        frameblock_id,
    output logic              frameblock_ready,
    input  logic              frameblock_next,
    output logic              frame_end
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [6:0] LAST_ID = 7'(NUM_BLOCKS - 1);

    // Ownership state: which bank each side points at, which banks hold a
    // committed block, and the id stamped on each bank at commit time.
    logic            wb_q, wb_d;
    logic            rb_q, rb_d;
    logic [1:0]      full_q, full_d;
    logic [1:0][6:0] id_tag_q, id_tag_d;
    logic [6:0]      next_id_q, next_id_d;
    logic            frame_end_q, frame_end_d;
    logic [15:0]     fb_data_q;

    // Both banks live in one array; the top address bit selects the bank.
    logic [15:0] mem [0:2*DEPTH-1];

    logic commit;
    logic release_front;

    assign render_ready     = !full_q[wb_q];
    assign render_block_id  = next_id_q;
    assign frameblock_ready = full_q[rb_q];
    assign frameblock_id    = id_tag_q[rb_q];
    assign frameblock_data  = fb_data_q;
    assign frame_end        = frame_end_q;

    assign commit        = render_done && render_ready;
    assign release_front = frameblock_next && full_q[rb_q];

    // Next-state for ownership. A commit and a release in the same cycle
    // always touch different banks, so both updates are applied.
    always_comb begin
        wb_d        = wb_q;
        rb_d        = rb_q;
        full_d      = full_q;
        id_tag_d    = id_tag_q;
        next_id_d   = next_id_q;
        frame_end_d = 1'b0;
        if (commit) begin
            full_d[wb_q]   = 1'b1;
            id_tag_d[wb_q] = next_id_q;
            wb_d           = !wb_q;
            next_id_d      = (next_id_q == LAST_ID) ? 7'd0 : next_id_q + 7'd1;
        end
        if (release_front) begin
            full_d[rb_q] = 1'b0;
            rb_d         = !rb_q;
            frame_end_d  = (id_tag_q[rb_q] == LAST_ID);
        end
    end

    // Ownership registers; reset drops any block in flight in either bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= 2'b00;
            id_tag_q    <= '0;
            next_id_q   <= 7'd0;
            frame_end_q <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            id_tag_q    <= id_tag_d;
            next_id_q   <= next_id_d;
            frame_end_q <= frame_end_d;
        end
    end

    // Pixel writes into the back bank; a write alongside render_done lands
    // in the bank being closed because wb_q has not flipped yet.
    always_ff @(posedge clk) begin
        if (render_we && render_ready) begin
            mem[{wb_q, render_addr}] <= render_data;
        end
    end

    // Registered read of the front bank, using the read pointer as it stands
    // on this edge (a release on the same edge affects the next read).
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_data_q <= 16'h0000;
        end else begin
            fb_data_q <= mem[{rb_q, frameblock_addr}];
        end
    end

endmodule

// File: tb/tb_frameblock_buffer.sv
// tb_frameblock_buffer: directed vector table, hand sequences for frame wrap
// and reset, then randomized traffic against a queue-based ownership model.
module tb_frameblock_buffer;

    localparam int NB = 75;
    localparam int RA = 32;  // address window used by random traffic

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  render_addr;
    logic [15:0] render_data;
    logic        render_we;
    logic        render_done;
    logic        render_ready;
    logic [6:0]  render_block_id;
    logic [9:0]  frameblock_addr;
    logic [15:0] frameblock_data;
    logic [6:0]  frameblock_id;
    logic        frameblock_ready;
    logic        frameblock_next;
    logic        frame_end;

    int checks = 0;
    int errors = 0;

    frameblock_buffer #(.NUM_BLOCKS(NB), .ADDR_W(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .render_addr      (render_addr),
        .render_data      (render_data),
        .render_we        (render_we),
        .render_done      (render_done),
        .render_ready     (render_ready),
        .render_block_id  (render_block_id),
        .frameblock_addr  (frameblock_addr),
        .frameblock_data  (frameblock_data),
        .frameblock_id    (frameblock_id),
        .frameblock_ready (frameblock_ready),
        .frameblock_next  (frameblock_next),
        .frame_end        (frame_end)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        render_addr     = '0;
        render_data     = '0;
        render_we       = 1'b0;
        render_done     = 1'b0;
        frameblock_addr = '0;
        frameblock_next = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int rr, input int rid, input int fr,
                              input int fid, input int fd, input int fe);
        check({tag, " render_ready"}, int'(render_ready), rr);
        check({tag, " render_block_id"}, int'(render_block_id), rid);
        check({tag, " frameblock_ready"}, int'(frameblock_ready), fr);
        check({tag, " frameblock_id"}, int'(frameblock_id), fid);
        if (fd >= 0) check({tag, " frameblock_data"}, int'(frameblock_data), fd);
        check({tag, " frame_end"}, int'(frame_end), fe);
    endtask

    // ---------------- vector table ----------------
    // Each record: inputs held for one cycle, outputs expected after that edge.
    typedef struct {
        logic        we;
        logic [9:0]  waddr;
        logic [15:0] wdata;
        logic        done;
        logic        next;
        logic [9:0]  raddr;
        logic        rr;
        logic [6:0]  rid;
        logic        fr;
        logic [6:0]  fid;
        logic        chk_d;
        logic [15:0] fd;
        logic        fe;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(int we, int waddr, int wdata, int done, int next, int raddr,
                                 int rr, int rid, int fr, int fid, int chk_d, int fd, int fe);
        vec_t v;
        v.we = 1'(we); v.waddr = 10'(waddr); v.wdata = 16'(wdata);
        v.done = 1'(done); v.next = 1'(next); v.raddr = 10'(raddr);
        v.rr = 1'(rr); v.rid = 7'(rid); v.fr = 1'(fr); v.fid = 7'(fid);
        v.chk_d = 1'(chk_d); v.fd = 16'(fd); v.fe = 1'(fe);
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Committed blocks form a FIFO of at most two; the oldest is on display.
    int q_bank[$];
    int q_id[$];
    int wb_m, nid_m;
    int tag_m[2];
    int mem_m[2][RA];
    int exp_fd, exp_fe;

    task automatic model_reset();
        q_bank.delete();
        q_id.delete();
        wb_m = 0;
        nid_m = 0;
        tag_m[0] = 0;
        tag_m[1] = 0;
        exp_fd = 0;
        exp_fe = 0;
    endtask

    task automatic model_cycle(input int we, input int waddr, input int wdata, input int done,
                               input int next, input int raddr);
        int front_bank;
        bit room;
        room = (q_bank.size() < 2);
        front_bank = (q_bank.size() > 0) ? q_bank[0] : wb_m;
        exp_fd = mem_m[front_bank][raddr];
        exp_fe = (next != 0 && q_bank.size() > 0 && q_id[0] == NB - 1) ? 1 : 0;
        if (we != 0 && room) mem_m[wb_m][waddr] = wdata;
        if (next != 0 && q_bank.size() > 0) begin
            void'(q_bank.pop_front());
            void'(q_id.pop_front());
        end
        if (done != 0 && room) begin
            q_bank.push_back(wb_m);
            q_id.push_back(nid_m);
            tag_m[wb_m] = nid_m;
            wb_m = 1 - wb_m;
            nid_m = (nid_m + 1) % NB;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int fe_count;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_outs("reset", 1, 0, 0, 0, 0, 0);

        // Directed vectors: commit, fill both banks, drop while full, release,
        // simultaneous commit/release, release while empty.
        vecs[0]  = mkv(1, 5, 16'h0005, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 6, 16'h1234, 1, 0, 5, 1, 1, 1, 0, 1, 16'h0005, 0);
        vecs[2]  = mkv(0, 0, 0,        0, 0, 6, 1, 1, 1, 0, 1, 16'h1234, 0);
        vecs[3]  = mkv(1, 5, 16'hBEEF, 1, 0, 5, 0, 2, 1, 0, 1, 16'h0005, 0);
        vecs[4]  = mkv(1, 5, 16'hDEAD, 1, 0, 5, 0, 2, 1, 0, 1, 16'h0005, 0);
        vecs[5]  = mkv(0, 0, 0,        0, 1, 5, 1, 2, 1, 1, 1, 16'h0005, 0);
        vecs[6]  = mkv(0, 0, 0,        0, 0, 5, 1, 2, 1, 1, 1, 16'hBEEF, 0);
        vecs[7]  = mkv(1, 7, 16'h7777, 1, 1, 5, 1, 3, 1, 2, 1, 16'hBEEF, 0);
        vecs[8]  = mkv(0, 0, 0,        0, 0, 7, 1, 3, 1, 2, 1, 16'h7777, 0);
        vecs[9]  = mkv(0, 0, 0,        0, 0, 5, 1, 3, 1, 2, 1, 16'h0005, 0);
        vecs[10] = mkv(0, 0, 0,        0, 1, 7, 1, 3, 0, 1, 1, 16'h7777, 0);
        vecs[11] = mkv(0, 0, 0,        0, 1, 5, 1, 3, 0, 1, 1, 16'hBEEF, 0);

        for (int i = 0; i < 12; i++) begin
            render_we       = vecs[i].we;
            render_addr     = vecs[i].waddr;
            render_data     = vecs[i].wdata;
            render_done     = vecs[i].done;
            frameblock_next = vecs[i].next;
            frameblock_addr = vecs[i].raddr;
            step();
            check_outs($sformatf("vec%0d", i), int'(vecs[i].rr), int'(vecs[i].rid),
                       int'(vecs[i].fr), int'(vecs[i].fid),
                       vecs[i].chk_d ? int'(vecs[i].fd) : -1, int'(vecs[i].fe));
        end
        idle_inputs();

        // Stream 80 blocks: ids wrap after NB-1 and frame_end pulses exactly once.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fe_count = 0;
        for (int k = 0; k < 80; k++) begin
            check("stream render_block_id", int'(render_block_id), k % NB);
            render_done = 1'b1;
            step();
            render_done = 1'b0;
            check("stream frameblock_ready", int'(frameblock_ready), 1);
            check("stream frameblock_id", int'(frameblock_id), k % NB);
            frameblock_next = 1'b1;
            step();
            frameblock_next = 1'b0;
            check("stream frame_end", int'(frame_end), (k % NB == NB - 1) ? 1 : 0);
            if (frame_end) fe_count++;
            step();
            check("stream frame_end width", int'(frame_end), 0);
        end
        check("stream frame_end count", fe_count, 1);

        // Reset in the middle of filling: one block committed, another half written.
        render_we = 1'b1;
        render_addr = 10'd3;
        render_data = 16'hAAAA;
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        render_addr = 10'd4;
        frameblock_addr = 10'd3;
        step();
        check("midfill data before reset", int'(frameblock_data), 16'hAAAA);
        render_we = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_outs("midfill reset", 1, 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < RA; a++) mem_m[b][a] = -1;
        idle_inputs();
        rst = 1'b1;
        step();
        model_reset();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r, we, wa, wd, dn, nx, ra;
            r  = ($urandom_range(0, 999) == 0) ? 1 : 0;
            we = r ? 0 : int'($urandom_range(0, 1));
            wa = int'($urandom_range(0, RA - 1));
            wd = int'($urandom_range(0, 16'hFFFF));
            dn = (r == 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            nx = (r == 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            ra = int'($urandom_range(0, RA - 1));
            rst = 1'(r);
            render_we = 1'(we);
            render_addr = 10'(wa);
            render_data = 16'(wd);
            render_done = 1'(dn);
            frameblock_next = 1'(nx);
            frameblock_addr = 10'(ra);
            if (r != 0) model_reset();
            else model_cycle(we, wa, wd, dn, nx, ra);
            step();
            check_outs("rand", (q_bank.size() < 2) ? 1 : 0, nid_m,
                       (q_bank.size() > 0) ? 1 : 0,
                       (q_bank.size() > 0) ? q_id[0] : tag_m[wb_m], exp_fd, exp_fe);
        end
        rst = 1'b0;
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
